rsa_modexp_core: RTL and testbench

- Parametrised iterative modular-exponentiation engine: result = base^exponent mod modulus.
- Next-generation replacement for the fixed-width mod-exp stage inside the RSA control path, with separate modulus and exponent widths, a start/busy/done handshake, error reporting, and handling of unreduced bases.
- Sits after the key-inverter stage; the control FSM loads operands, pulses start and waits for done.

---
 rtl/rsa_modexp_core.sv | 188 ++++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: iterative modular exponentiation, result = base^exponent mod modulus.
// Left-to-right square-and-multiply over an interleaved shift-add modular multiplier
// (WIDTH cycles per multiply, WIDTH+2 bit accumulator).
// Optional macro RSA_MODEXP_FAST_EN: variable-time mode that skips leading zero
// exponent bits and the multiply of zero bits. Default build is constant time.
module rsa_modexp_core #(
   parameter int WIDTH     = 128,
   parameter int EXP_WIDTH = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     base,
   input  logic [EXP_WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0]     modulus,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [WIDTH-1:0]     result
);

   localparam int TW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int EW = $clog2(EXP_WIDTH + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_REDUCE = 3'd2;
   localparam logic [2:0] S_SQUARE = 3'd3;
   localparam logic [2:0] S_MULT   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]           state;
   logic [WIDTH-1:0]     base_q, mod_q, r_q, bred_q;
   logic [EXP_WIDTH-1:0] exp_q, exp_sh;
   logic [EW-1:0]        exp_left;
   logic [TW-1:0]        t_acc, t_next, mul_a;
   logic [WIDTH-1:0]     mul_b;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     prod, r_after_mult;
   logic                 mul_last, cur_bit, last_bit;

   // One interleaved step: T = 2T + (b ? A : 0), then at most two conditional
   // subtractions of N bring T back below N (2T + A < 3N when T, A < N).
   function automatic logic [TW-1:0] mod_step(input logic [TW-1:0] t,
                                              input logic [TW-1:0] a,
                                              input logic          b,
                                              input logic [TW-1:0] n);
      logic [TW-1:0] s;
      s = (t << 1) + (b ? a : '0);
      if (s >= n) s = s - n;
      if (s >= n) s = s - n;
      return s;
   endfunction

`ifdef RSA_MODEXP_FAST_EN
   // Number of zero bits above the highest set exponent bit.
   function automatic logic [EW-1:0] lead_zeros(input logic [EXP_WIDTH-1:0] e);
      logic [EW-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = EXP_WIDTH - 1; i >= 0; i--) begin
         if (e[i]) found = 1'b1;
         else if (!found) n = n + EW'(1);
      end
      return n;
   endfunction

   logic [EW-1:0] lz;
   assign lz = lead_zeros(exp_q);
`endif

   // Next multiplier accumulator value, scanning B from its MSB.
   always_comb begin
      t_next = mod_step(t_acc, mul_a, mul_b[WIDTH-1], {2'b00, mod_q});
   end

   assign mul_last     = (cnt == CW'(WIDTH - 1));
   assign prod         = t_next[WIDTH-1:0];
   assign cur_bit      = exp_sh[EXP_WIDTH-1];
   assign last_bit     = (exp_left == EW'(1));
   assign r_after_mult = cur_bit ? prod : r_q;

   // Control FSM and datapath; reset touches control and visible outputs only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  base_q <= base;
                  exp_q  <= exponent;
                  mod_q  <= modulus;
                  busy   <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               err   <= 1'b0;
               t_acc <= '0;
               cnt   <= '0;
               mul_a <= TW'(1);
               mul_b <= base_q;
               if (mod_q == '0) begin
                  r_q   <= '0;
                  state <= S_DONE;
               end else begin
                  r_q   <= (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                  state <= S_REDUCE;
               end
            end
            S_REDUCE: begin
               t_acc <= t_next;
               mul_b <= mul_b << 1;
               cnt   <= cnt + CW'(1);
               if (mul_last) begin
                  bred_q <= prod;
                  t_acc  <= '0;
                  cnt    <= '0;
                  mul_a  <= {2'b00, r_q};
                  mul_b  <= r_q;
`ifdef RSA_MODEXP_FAST_EN
                  exp_sh   <= exp_q << lz;
                  exp_left <= EW'(EXP_WIDTH) - lz;
                  state    <= (exp_q == '0) ? S_DONE : S_SQUARE;
`else
                  exp_sh   <= exp_q;
                  exp_left <= EW'(EXP_WIDTH);
                  state    <= S_SQUARE;
`endif
               end
            end
            S_SQUARE: begin
               t_acc <= t_next;
               mul_b <= mul_b << 1;
               cnt   <= cnt + CW'(1);
               if (mul_last) begin
                  r_q   <= prod;
                  t_acc <= '0;
                  cnt   <= '0;
                  mul_a <= {2'b00, prod};
                  mul_b <= bred_q;
                  state <= S_MULT;
`ifdef RSA_MODEXP_FAST_EN
                  if (!cur_bit) begin
                     mul_b    <= prod;
                     exp_sh   <= exp_sh << 1;
                     exp_left <= exp_left - EW'(1);
                     state    <= last_bit ? S_DONE : S_SQUARE;
                  end
`endif
               end
            end
            S_MULT: begin
               t_acc <= t_next;
               mul_b <= mul_b << 1;
               cnt   <= cnt + CW'(1);
               if (mul_last) begin
                  r_q      <= r_after_mult;
                  t_acc    <= '0;
                  cnt      <= '0;
                  mul_a    <= {2'b00, r_after_mult};
                  mul_b    <= r_after_mult;
                  exp_sh   <= exp_sh << 1;
                  exp_left <= exp_left - EW'(1);
                  state    <= last_bit ? S_DONE : S_SQUARE;
               end
            end
            S_DONE: begin
               result <= r_q;
               done   <= 1'b1;
               busy   <= 1'b0;
               err    <= (mod_q == '0);
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: directed and randomized checks of rsa_modexp_core against a
// plain-arithmetic reference model (8-bit instance plus two 128-bit RSA instances).
module tb_rsa_modexp_core;

   localparam int SW = 8;
   localparam int SE = 8;
   localparam int BW = 128;
   localparam int BE = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          s_start, s_busy, s_done, s_err;
   logic [SW-1:0] s_base, s_mod, s_result;
   logic [SE-1:0] s_exp;

   logic          a_start, a_busy, a_done, a_err;
   logic [BW-1:0] a_base, a_mod, a_result;
   logic [BE-1:0] a_exp;
   logic          b_start, b_busy, b_done, b_err;
   logic [BW-1:0] b_base, b_mod, b_result;
   logic [BE-1:0] b_exp;

   int checks = 0;
   int errors = 0;

   rsa_modexp_core #(.WIDTH(SW), .EXP_WIDTH(SE)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .base(s_base), .exponent(s_exp),
      .modulus(s_mod), .busy(s_busy), .done(s_done), .err(s_err), .result(s_result));

   rsa_modexp_core #(.WIDTH(BW), .EXP_WIDTH(BE)) u_enc (
      .clk(clk), .reset(reset), .start(a_start), .base(a_base), .exponent(a_exp),
      .modulus(a_mod), .busy(a_busy), .done(a_done), .err(a_err), .result(a_result));

   rsa_modexp_core #(.WIDTH(BW), .EXP_WIDTH(BE)) u_dec (
      .clk(clk), .reset(reset), .start(b_start), .base(b_base), .exponent(b_exp),
      .modulus(b_mod), .busy(b_busy), .done(b_done), .err(b_err), .result(b_result));

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: right-to-left binary exponentiation with wide integer arithmetic.
   function automatic logic [255:0] ref_modexp(input logic [255:0] b, input logic [255:0] e,
                                               input logic [255:0] n);
      logic [511:0] r, x, nn;
      if (n == '0) return '0;
      nn = '0; nn[255:0] = n;
      x  = '0; x[255:0]  = b;
      r  = 512'd1 % nn;
      x  = x % nn;
      for (int i = 0; i < 256; i++) begin
         if (e[i]) r = (r * x) % nn;
         x = (x * x) % nn;
      end
      return r[255:0];
   endfunction

   // Expected start-to-done latency in cycles.
   function automatic int ref_lat(input int w, input int ew, input logic [255:0] e,
                                  input logic [255:0] n);
      int k, p;
      k = 0; p = 0;
      if (n == '0) return 2;
      for (int i = 0; i < 256; i++) if (e[i]) begin k = i + 1; p++; end
`ifdef RSA_MODEXP_FAST_EN
      return 2 + w + w * (k + p);
`else
      return 2 + w + 2 * ew * w;
`endif
   endfunction

   // Modular inverse via the extended Euclidean algorithm.
   function automatic logic [127:0] mod_inverse(input logic [127:0] a, input logic [127:0] m);
      logic signed [263:0] t, nt, r, nr, q, tmp;
      t = '0; nt = '0; nt[0] = 1'b1;
      r = '0; r[127:0] = m;
      nr = '0; nr[127:0] = a;
      while (nr != '0) begin
         q   = r / nr;
         tmp = t - q * nt; t = nt; nt = tmp;
         tmp = r - q * nr; r = nr; nr = tmp;
      end
      if (t < 0) begin
         tmp = '0; tmp[127:0] = m;
         t = t + tmp;
      end
      return t[127:0];
   endfunction

   // One operation on the 8-bit instance; optionally pulses start mid-operation
   // with different operands, which must have no effect.
   task automatic run_small(input logic [7:0] b, input logic [7:0] e, input logic [7:0] n,
                            input logic [7:0] exp_res, input bit interfere, input string tag);
      int lat, exp_l;
      bit seen, overlap;
      exp_l = ref_lat(SW, SE, 256'(e), 256'(n));
      @(negedge clk);
      s_base = b; s_exp = e; s_mod = n; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      check({tag, "_busy"}, 256'(s_busy), 256'(1));
      lat = 0; seen = 1'b0; overlap = 1'b0;
      while (!seen && lat < exp_l + 40) begin
         if (interfere && lat == 20) begin
            s_start = 1'b1; s_base = b + 8'd1; s_exp = e + 8'd3; s_mod = n + 8'd5;
         end else begin
            s_start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
         if (lat == 1) check({tag, "_err_clear"}, 256'(s_err), 256'(0));
         if (s_busy && s_done) overlap = 1'b1;
         if (s_done) seen = 1'b1;
      end
      s_start = 1'b0;
      check({tag, "_done_seen"}, 256'(seen), 256'(1));
      check({tag, "_latency"}, 256'(lat), 256'(exp_l));
      check({tag, "_result"}, 256'(s_result), 256'(exp_res));
      check({tag, "_err"}, 256'(s_err), 256'(n == 8'd0));
      check({tag, "_overlap"}, 256'(overlap), 256'(0));
      @(posedge clk); #1;
      check({tag, "_pulse"}, 256'(s_done), 256'(0));
      check({tag, "_hold"}, 256'(s_result), 256'(exp_res));
   endtask

   initial begin
      logic [7:0]   rb, re, rn;
      logic [127:0] p_v, q_v, n_v, phi_v, e_v, d_v, m_v, c_v;
      int           la, lb, cyc, spurious, exp_la, exp_lb;
      bit           sa, sb;

      reset = 1'b1;
      s_start = 1'b0; s_base = '0; s_exp = '0; s_mod = '0;
      a_start = 1'b0; a_base = '0; a_exp = '0; a_mod = '0;
      b_start = 1'b0; b_base = '0; b_exp = '0; b_mod = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 256'(s_busy), 256'(0));
      check("rst_done", 256'(s_done), 256'(0));
      check("rst_err", 256'(s_err), 256'(0));
      check("rst_result", 256'(s_result), 256'(0));
      reset = 1'b0;

      // Directed values from the textbook 187 = 11*17 key.
      run_small(8'd88, 8'd7, 8'd187, 8'd11, 1'b0, "enc88");
      check("enc88_L138", 256'(ref_lat(SW, SE, 256'd7, 256'd187)),
`ifdef RSA_MODEXP_FAST_EN
            256'(58));
`else
            256'(138));
`endif
      run_small(8'd11, 8'd23, 8'd187, 8'd88, 1'b0, "dec11");
      run_small(8'd4, 8'd13, 8'd187, 8'd174, 1'b0, "pow4");
      run_small(8'd200, 8'd1, 8'd187, 8'd13, 1'b0, "unreduced");
      run_small(8'd123, 8'd0, 8'd187, 8'd1, 1'b0, "exp0");
      run_small(8'd77, 8'd45, 8'd1, 8'd0, 1'b0, "mod1");
      run_small(8'd77, 8'd0, 8'd1, 8'd0, 1'b0, "mod1_exp0");
      run_small(8'd99, 8'd5, 8'd0, 8'd0, 1'b0, "mod0");
      @(posedge clk); #1;
      check("mod0_err_held", 256'(s_err), 256'(1));
      run_small(8'd2, 8'd10, 8'd255, 8'd4, 1'b0, "after_mod0");
      run_small(8'd88, 8'd7, 8'd187, 8'd11, 1'b1, "start_busy");

      // Reset at cycle 50 of an operation aborts it without a done pulse.
      @(negedge clk);
      s_base = 8'd11; s_exp = 8'd23; s_mod = 8'd187; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      repeat (49) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 256'(s_busy), 256'(0));
      check("abort_done", 256'(s_done), 256'(0));
      check("abort_result", 256'(s_result), 256'(0));
      spurious = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (s_done || s_busy) spurious++;
      end
      check("abort_quiet", 256'(spurious), 256'(0));
      run_small(8'd11, 8'd23, 8'd187, 8'd88, 1'b0, "post_abort");

      // Randomized operands, including degenerate moduli.
      for (int i = 0; i < 12; i++) begin
         rb = 8'($urandom_range(0, 255));
         re = 8'($urandom_range(0, 255));
         case ($urandom_range(0, 7))
            0:       rn = 8'd0;
            1:       rn = 8'd1;
            default: rn = 8'($urandom_range(2, 255));
         endcase
         run_small(rb, re, rn, 8'(ref_modexp(256'(rb), 256'(re), 256'(rn))), 1'b0, "rand");
      end

      // 128-bit RSA: encrypt m and, in parallel, decrypt the reference ciphertext.
      p_v   = 128'd8475698667747010771;
      q_v   = 128'd11297384090418420749;
      n_v   = p_v * q_v;
      phi_v = (p_v - 128'd1) * (q_v - 128'd1);
      e_v   = 128'd65537;
      d_v   = mod_inverse(e_v, phi_v);
      m_v   = 128'hebe2596d9d;
      c_v   = 128'(ref_modexp(256'(m_v), 256'(e_v), 256'(n_v)));
      exp_la = ref_lat(BW, BE, 256'(e_v), 256'(n_v));
      exp_lb = ref_lat(BW, BE, 256'(d_v), 256'(n_v));
      @(negedge clk);
      a_base = m_v; a_exp = e_v; a_mod = n_v; a_start = 1'b1;
      b_base = c_v; b_exp = d_v; b_mod = n_v; b_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0; b_start = 1'b0;
      cyc = 0; sa = 1'b0; sb = 1'b0; la = 0; lb = 0;
      while (!(sa && sb) && cyc < 2 + BW + 2 * BE * BW + 50) begin
         @(posedge clk); #1;
         cyc++;
         if (a_done && !sa) begin sa = 1'b1; la = cyc; end
         if (b_done && !sb) begin sb = 1'b1; lb = cyc; end
      end
      check("rsa_enc_done", 256'(sa), 256'(1));
      check("rsa_dec_done", 256'(sb), 256'(1));
      check("rsa_enc_latency", 256'(la), 256'(exp_la));
      check("rsa_dec_latency", 256'(lb), 256'(exp_lb));
      check("rsa_enc_result", 256'(a_result), 256'(c_v));
      check("rsa_dec_result", 256'(b_result), 256'(m_v));
      check("rsa_err", 256'({a_err, b_err}), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
